// File: rtl/control_multiciclo.sv
// -----------------------------------------------------------------------------
// control_multiciclo
// Multicycle main control FSM for the RV32I+M subset (lw, sw, R/I-type ALU ops,
// beq/bne, jal, mul/divu/remu). Sequences the shared memory path, the ALU and
// the external iterative mul/div unit through fetch, decode, execute, memory
// and writeback steps.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset, forces FETCH
//   op           instruction[6:0]
//   funct3       instruction[14:12]
//   funct7b0     instruction[25], M-extension select
//   funct7b5     instruction[30], sub select
//   zero         ALU zero flag (current cycle)
//   m_done       one-cycle result-valid pulse from the mul/div unit
//   pc_write, ir_write, reg_write, mem_write   write enables
//   adr_src      memory address select (0 PC, 1 alu_out)
//   alu_src_a    00 PC, 01 old_pc, 10 register A
//   alu_src_b    00 register B, 01 immediate, 10 constant 4
//   result_src   00 alu_out, 01 read data, 10 ALU result, 11 m_result
//   imm_src      00 I, 01 S, 10 B, 11 J (decoded from op alone)
//   alu_control  0000 add, 0001 sub, 0010 and, 0011 or, 0101 slt
//   m_start      one-cycle start pulse to the mul/div unit
//   halted       high while in HALT
// -----------------------------------------------------------------------------
module control_multiciclo (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b0,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       m_done,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [3:0] alu_control,
    output logic       m_start,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_MSTART   = 4'd11,
        S_MWAIT    = 4'd12,
        S_MWB      = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    state_t state_r;
    state_t next_state_s;

    // funct3 -> ALU operation; unsupported encodings fall back to add
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub_en);
        logic [3:0] res;
        case (f3)
            3'b000:  res = sub_en ? ALU_SUB : ALU_ADD;
            3'b111:  res = ALU_AND;
            3'b110:  res = ALU_OR;
            3'b010:  res = ALU_SLT;
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

    // State register, synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH:  next_state_s = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = funct7b0 ? S_MSTART : S_EXECR;
                    OP_ITYPE:     next_state_s = S_EXECI;
                    OP_BRANCH:    next_state_s = S_BRANCH;
                    OP_JAL:       next_state_s = S_JAL;
                    default:      next_state_s = S_HALT;
                endcase
            end
            // Only lw and sw reach MEMADR, so op distinguishes them
            S_MEMADR: begin
                if (op == OP_LW) begin
                    next_state_s = S_MEMREAD;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_MEMREAD:  next_state_s = S_MEMWB;
            S_MEMWB:    next_state_s = S_FETCH;
            S_MEMWRITE: next_state_s = S_FETCH;
            S_EXECR:    next_state_s = S_ALUWB;
            S_EXECI:    next_state_s = S_ALUWB;
            S_ALUWB:    next_state_s = S_FETCH;
            S_BRANCH: begin
                if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_HALT;
                end
            end
            S_JAL:    next_state_s = S_ALUWB;
            S_MSTART: next_state_s = S_MWAIT;
            // m_done is only looked at here; pulses elsewhere are ignored
            S_MWAIT: begin
                if (m_done) begin
                    next_state_s = S_MWB;
                end else begin
                    next_state_s = S_MWAIT;
                end
            end
            S_MWB:   next_state_s = S_FETCH;
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_HALT;
        endcase
    end

    // Output decode from state; everything forced idle while reset is high
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        imm_src     = 2'b00;
        alu_control = ALU_ADD;
        m_start     = 1'b0;
        halted      = 1'b0;
        if (reset) begin
            halted = 1'b0;
        end else begin
            case (op)
                OP_SW:     imm_src = 2'b01;
                OP_BRANCH: imm_src = 2'b10;
                OP_JAL:    imm_src = 2'b11;
                default:   imm_src = 2'b00;
            endcase
            case (state_r)
                S_FETCH: begin
                    ir_write   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: adr_src = 1'b1;
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a   = 2'b10;
                    alu_control = alu_decode(funct3, funct7b5);
                end
                // Immediate forms have no sub: bit 30 is immediate data
                S_EXECI: begin
                    alu_src_a   = 2'b10;
                    alu_src_b   = 2'b01;
                    alu_control = alu_decode(funct3, 1'b0);
                end
                S_ALUWB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a   = 2'b10;
                    alu_control = ALU_SUB;
                    case (funct3)
                        3'b000:  pc_write = zero;
                        3'b001:  pc_write = ~zero;
                        default: pc_write = 1'b0;
                    endcase
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                S_MSTART: m_start = 1'b1;
                S_MWAIT:  m_start = 1'b0;
                S_MWB: begin
                    result_src = 2'b11;
                    reg_write  = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: halted = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// -----------------------------------------------------------------------------
// Testbench for control_multiciclo. For each instruction a reference model
// expands the instruction class into the expected per-cycle output bundle
// (plus per-cycle zero / m_done stimulus); the DUT outputs are compared every
// cycle half a clock after the rising edge.
// -----------------------------------------------------------------------------
module tb_control_multiciclo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b0 = 1'b0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       m_done = 1'b0;
    logic       pc_write, ir_write, reg_write, mem_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [3:0] alu_control;
    logic       m_start, halted;

    always #5 clk = ~clk;

    control_multiciclo dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b0(funct7b0), .funct7b5(funct7b5), .zero(zero), .m_done(m_done),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_write(mem_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
        .alu_control(alu_control), .m_start(m_start), .halted(halted)
    );

    // {pcw, irw, rw, mw, adr, a[2], b[2], rs[2], imm[2], alu[4], m_start, halted}
    logic [18:0] obs;
    assign obs = {pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
                  alu_src_b, result_src, imm_src, alu_control, m_start, halted};

    logic [31:0] ins_q[$];
    logic [18:0] exp_q[$];
    logic        zero_q[$];
    logic        md_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [18:0] mk(input logic pcw, input logic irw, input logic rw,
                                       input logic mw, input logic adr, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] rs,
                                       input logic [3:0] alu, input logic ms, input logic h,
                                       input logic [1:0] im);
        return {pcw, irw, rw, mw, adr, a, b, rs, im, alu, ms, h};
    endfunction

    // ALU operation implied by funct3 (add for anything unlisted)
    function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic sub_en);
        if (f3 == 3'b111) return 4'b0010;
        if (f3 == 3'b110) return 4'b0011;
        if (f3 == 3'b010) return 4'b0101;
        if (f3 == 3'b000 && sub_en) return 4'b0001;
        return 4'b0000;
    endfunction

    // Random instruction of a class: 0 lw, 1 sw, 2 R, 3 I, 4 beq/bne, 5 jal, 6 M
    function automatic logic [31:0] gen(input int cls);
        logic [31:0] w;
        w = $urandom;
        case (cls)
            0: w[6:0] = 7'b0000011;
            1: w[6:0] = 7'b0100011;
            2: begin w[6:0] = 7'b0110011; w[25] = 1'b0; end
            3: w[6:0] = 7'b0010011;
            4: begin w[6:0] = 7'b1100011; w[14:13] = 2'b00; end
            5: w[6:0] = 7'b1101111;
            default: begin w[6:0] = 7'b0110011; w[25] = 1'b1; end
        endcase
        return w;
    endfunction

    // Append one expected cycle; md/z < 0 means "don't care, randomize"
    task automatic push(input logic [31:0] ins, input logic [18:0] e, input int md, input int z);
        ins_q.push_back(ins);
        exp_q.push_back(e);
        md_q.push_back((md < 0) ? 1'($urandom_range(1, 0)) : 1'(md));
        zero_q.push_back((z < 0) ? 1'($urandom_range(1, 0)) : 1'(z));
    endtask

    task automatic clear_q();
        ins_q.delete(); exp_q.delete(); zero_q.delete(); md_q.delete();
    endtask

    // Reference model: expected output bundle per cycle for one instruction
    task automatic build(input logic [31:0] ins, input int n_wait, input int bz, input int n_halt);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [1:0] im;
        logic       z;
        logic       pcw;
        opc = ins[6:0];
        f3  = ins[14:12];
        im  = (opc == 7'b0100011) ? 2'b01 : (opc == 7'b1100011) ? 2'b10 :
              (opc == 7'b1101111) ? 2'b11 : 2'b00;
        push(ins, mk(1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,4'b0000,1'b0,1'b0,im), -1, -1);
        push(ins, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,4'b0000,1'b0,1'b0,im), -1, -1);
        if (opc == 7'b0000011) begin
            push(ins, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,4'b0000,1'b0,1'b0,im), -1, -1);
            push(ins, mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,4'b0000,1'b0,1'b0,im), -1, -1);
            push(ins, mk(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b01,4'b0000,1'b0,1'b0,im), -1, -1);
        end else if (opc == 7'b0100011) begin
            push(ins, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,4'b0000,1'b0,1'b0,im), -1, -1);
            push(ins, mk(1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,2'b00,4'b0000,1'b0,1'b0,im), -1, -1);
        end else if (opc == 7'b0110011 && ins[25]) begin
            push(ins, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,1'b1,1'b0,im), -1, -1);
            for (int k = 0; k < n_wait; k++)
                push(ins, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,1'b0,1'b0,im), 0, -1);
            push(ins, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,1'b0,1'b0,im), 1, -1);
            push(ins, mk(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b11,4'b0000,1'b0,1'b0,im), -1, -1);
        end else if (opc == 7'b0110011 || opc == 7'b0010011) begin
            if (opc == 7'b0110011)
                push(ins, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,exp_alu(f3, ins[30]),1'b0,1'b0,im), -1, -1);
            else
                push(ins, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,exp_alu(f3, 1'b0),1'b0,1'b0,im), -1, -1);
            push(ins, mk(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,1'b0,1'b0,im), -1, -1);
        end else if (opc == 7'b1100011) begin
            z   = (bz < 0) ? 1'($urandom_range(1, 0)) : 1'(bz);
            pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
            push(ins, mk(pcw,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,4'b0001,1'b0,1'b0,im), -1, int'(z));
            if (f3 != 3'b000 && f3 != 3'b001)
                for (int k = 0; k < n_halt; k++)
                    push(ins, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,1'b0,1'b1,im), -1, -1);
        end else if (opc == 7'b1101111) begin
            push(ins, mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b00,4'b0000,1'b0,1'b0,im), -1, -1);
            push(ins, mk(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,1'b0,1'b0,im), -1, -1);
        end else begin
            for (int k = 0; k < n_halt; k++)
                push(ins, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,1'b0,1'b1,im), -1, -1);
        end
    endtask

    // Apply the stimulus of queued cycle k and let outputs settle
    task automatic drive(input int k);
        logic [31:0] w;
        @(negedge clk);
        w        = ins_q[k];
        reset    = 1'b0;
        op       = w[6:0];
        funct3   = w[14:12];
        funct7b0 = w[25];
        funct7b5 = w[30];
        zero     = zero_q[k];
        m_done   = md_q[k];
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            reset = 1'b1;
            {funct7b5, funct7b0, funct3, op} = 12'($urandom);
            zero = 1'($urandom); m_done = 1'($urandom);
            #1;
            n_checks++;
            if (obs !== 19'd0) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %05h expected %05h", k, obs, 19'd0);
            end
        end
    endtask

    task automatic test_lw();
        clear_q();
        build(32'h00002283, 0, -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            drive(k);
            n_checks++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL lw cycle %0d: got %05h expected %05h", k, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_sw();
        clear_q();
        build(32'h0062a223, 0, -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            drive(k);
            n_checks++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL sw cycle %0d: got %05h expected %05h", k, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_branch();
        clear_q();
        build(32'h00730663, 0, 1, 0);
        build(32'h00730663, 0, 0, 0);
        for (int i = 0; i < 6; i++) build(gen(4), 0, -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            drive(k);
            n_checks++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL branch cycle %0d: got %05h expected %05h", k, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_alu_ops();
        clear_q();
        for (int i = 0; i < 24; i++) build(gen(2 + (i % 2)), 0, -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            drive(k);
            n_checks++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL alu_ops cycle %0d: got %05h expected %05h", k, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_mdiv();
        clear_q();
        build(32'h02554333, 7, -1, 0);
        for (int i = 0; i < 4; i++) build(gen(6), int'($urandom_range(10, 1)), -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            drive(k);
            n_checks++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL mdiv cycle %0d: got %05h expected %05h", k, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_jal();
        clear_q();
        build(32'hff5ff06f, 0, -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            drive(k);
            n_checks++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL jal cycle %0d: got %05h expected %05h", k, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        for (int i = 0; i < 20; i++) build(gen(int'($urandom_range(6, 0))), int'($urandom_range(4, 1)), -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            drive(k);
            n_checks++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %05h expected %05h", k, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_halt(input logic [31:0] ins);
        clear_q();
        build(ins, 0, -1, 20);
        for (int k = 0; k < exp_q.size(); k++) begin
            drive(k);
            n_checks++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL halt cycle %0d: got %05h expected %05h", k, obs, exp_q[k]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== 19'd0) begin
            n_fail++;
            $display("FAIL halt_reset: got %05h expected %05h", obs, 19'd0);
        end
        clear_q();
        build(gen(1), 0, -1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            drive(k);
            n_checks++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL halt_restart cycle %0d: got %05h expected %05h", k, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mwait();
        clear_q();
        build(gen(6), 10, -1, 0);
        // FETCH, DECODE, MSTART and three MWAIT cycles, then abort
        for (int k = 0; k < 6; k++) begin
            drive(k);
            n_checks++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL mwait_pre cycle %0d: got %05h expected %05h", k, obs, exp_q[k]);
            end
        end
        @(negedge clk);
        reset  = 1'b1;
        m_done = 1'b0;
        #1;
        n_checks++;
        if (obs !== 19'd0) begin
            n_fail++;
            $display("FAIL mwait_reset: got %05h expected %05h", obs, 19'd0);
        end
        // Stale m_done from the aborted operation lands during the next lw
        clear_q();
        build(gen(0), 0, -1, 0);
        md_q[0] = 1'b1;
        md_q[1] = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            drive(k);
            n_checks++;
            if (obs !== exp_q[k]) begin
                n_fail++;
                $display("FAIL mwait_after cycle %0d: got %05h expected %05h", k, obs, exp_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_branch();
        test_alu_ops();
        test_mdiv();
        test_jal();
        test_back_to_back();
        test_halt(32'h00000000);
        test_halt(32'h00732663);
        test_reset_mwait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
